// File: rtl/seg7_rx_decoder_if.sv
// seg7_rx_decoder_if: active-low segment/enable bus plus decoded digit outputs
interface seg7_rx_decoder_if;
    logic [7:0]  c;
    logic [7:0]  en;
    logic [3:0]  digit;
    logic [2:0]  digit_idx;
    logic        dp;
    logic        valid;
    logic        err;
    logic [31:0] hex_word;
    logic        frame_done;
    modport master (output c, en, input digit, digit_idx, dp, valid, err, hex_word, frame_done);
    modport slave (input c, en, output digit, digit_idx, dp, valid, err, hex_word, frame_done);
endinterface

// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: debounces the multiplexed 7-segment bus and rebuilds the 8-digit hex word
module seg7_rx_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_rx_decoder_if.slave  bus
);
    typedef enum logic {WAIT, HELD} state_t;
    localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);
    state_t      state, state_d;
    logic [15:0] s_q, run, run_d;
    logic [7:0]  mask, mask_n, enz;
    logic [3:0]  dec;
    logic [2:0]  idx;
    logic        chg, eval, legal, one_hot;
    assign chg     = {bus.en, bus.c} != s_q;
    assign run_d   = chg ? 16'd1 : (run == STABLE ? run : run + 16'd1);
    assign enz     = ~s_q[15:8];
    assign one_hot = enz != 8'd0 && (enz & (enz - 8'd1)) == 8'd0;
    assign mask_n  = mask | (8'd1 << idx);
    always_comb begin
        eval    = state == WAIT && run == STABLE;
        state_d = chg ? WAIT : (eval ? HELD : state);
    end
    always_comb begin
        legal = 1'b1;
        dec   = 4'h0;
        case (s_q[6:0])
            7'h40: dec = 4'h0;
            7'h79: dec = 4'h1;
            7'h24: dec = 4'h2;
            7'h30: dec = 4'h3;
            7'h19: dec = 4'h4;
            7'h12: dec = 4'h5;
            7'h02: dec = 4'h6;
            7'h78: dec = 4'h7;
            7'h00: dec = 4'h8;
            7'h10: dec = 4'h9;
            7'h08: dec = 4'hA;
            7'h03: dec = 4'hB;
            7'h46: dec = 4'hC;
            7'h21: dec = 4'hD;
            7'h06: dec = 4'hE;
            7'h0E: dec = 4'hF;
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (enz[i]) idx = 3'(i);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT;
        else state <= state_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q            <= 16'hFFFF;
            run            <= 16'd0;
            mask           <= 8'd0;
            bus.digit      <= 4'd0;
            bus.digit_idx  <= 3'd0;
            bus.dp         <= 1'b0;
            bus.valid      <= 1'b0;
            bus.err        <= 1'b0;
            bus.hex_word   <= 32'd0;
            bus.frame_done <= 1'b0;
        end else begin
            s_q            <= {bus.en, bus.c};
            run            <= run_d;
            bus.valid      <= 1'b0;
            bus.err        <= 1'b0;
            bus.frame_done <= 1'b0;
            // a blank bus (no enable low) is silently ignored
            if (eval && enz != 8'd0) begin
                if (!one_hot || !legal) bus.err <= 1'b1;
                else begin
                    bus.valid                      <= 1'b1;
                    bus.digit                      <= dec;
                    bus.dp                         <= ~s_q[7];
                    bus.digit_idx                  <= idx;
                    bus.hex_word[{idx, 2'b00} +: 4] <= dec;
                    bus.frame_done                 <= &mask_n;
                    mask                           <= &mask_n ? 8'd0 : mask_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_rx_decoder.sv
// tb_seg7_rx_decoder: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_seg7_rx_decoder;
    typedef struct {
        bit          is_err;
        logic [3:0]  d;
        logic [2:0]  idx;
        logic        dp;
        logic [31:0] hw;
        logic        fd;
        int          cyc;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    ev_t q[$];
    logic [31:0] exp_hex = 32'd0;
    logic [7:0] exp_mask = 8'd0;
    logic [7:0] codes [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    seg7_rx_decoder_if bus();
    seg7_rx_decoder #(.STABLE_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic exp_valid(input int p, input logic [3:0] d, input logic dpv);
        ev_t e;
        exp_hex[p*4 +: 4] = d;
        exp_mask[p] = 1'b1;
        e.fd = &exp_mask;
        if (e.fd) exp_mask = 8'd0;
        e.is_err = 1'b0;
        e.d = d;
        e.idx = 3'(p);
        e.dp = dpv;
        e.hw = exp_hex;
        e.cyc = cyc + 17;
        q.push_back(e);
    endtask
    task automatic exp_err();
        ev_t e;
        e = '{is_err: 1'b1, d: 4'd0, idx: 3'd0, dp: 1'b0, hw: exp_hex, fd: 1'b0, cyc: cyc + 17};
        q.push_back(e);
    endtask
    task automatic hold(input logic [7:0] e, input logic [7:0] cc, input int n);
        bus.en = e;
        bus.c = cc;
        repeat (n) @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() != 0 && q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_event: got nothing expected event at cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.frame_done) chk("fd_with_valid", 32'(bus.valid), 32'd1);
            if (bus.valid || bus.err) begin
                chk("valid_err_excl", 32'(bus.valid & bus.err), 32'd0);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got valid=%0b err=%0b expected none (cycle %0d)", bus.valid, bus.err, cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("err", 32'(bus.err), 32'(e.is_err));
                    chk("hex_word", bus.hex_word, e.hw);
                    chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
                    if (!e.is_err) begin
                        chk("digit", 32'(bus.digit), 32'(e.d));
                        chk("digit_idx", 32'(bus.digit_idx), 32'(e.idx));
                        chk("dp", 32'(bus.dp), 32'(e.dp));
                    end
                end
            end
        end
    end
    initial begin
        bus.en = 8'hFF;
        bus.c = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digit", 32'(bus.digit), 32'd0);
        chk("rst_idx", 32'(bus.digit_idx), 32'd0);
        chk("rst_dp", 32'(bus.dp), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_hex", bus.hex_word, 32'd0);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        hold(8'hFF, 8'hFF, 20);
        exp_valid(0, 4'h0, 1'b0);
        hold(8'hFE, 8'hC0, 20);
        hold(8'hFF, 8'hFF, 5);
        for (int i = 0; i < 8; i++) begin
            exp_valid(i, 4'(i), 1'b0);
            hold(~(8'd1 << i), codes[i], 20);
        end
        chk("frame_word", bus.hex_word, 32'h7654_3210);
        exp_valid(0, 4'h0, 1'b0);
        hold(8'hFE, 8'hC0, 20);
        hold(8'hFE, 8'hF9, 5);
        exp_valid(0, 4'h0, 1'b0);
        hold(8'hFE, 8'hC0, 20);
        exp_err();
        hold(8'hFE, 8'hFF, 20);
        exp_err();
        hold(8'hFC, 8'h40, 20);
        exp_valid(0, 4'h0, 1'b1);
        hold(8'hFE, 8'h40, 20);
        exp_valid(2, 4'h3, 1'b0);
        hold(8'hFB, 8'hB0, 16);
        hold(8'hFF, 8'hFF, 5);
        hold(8'hFB, 8'hB0, 15);
        hold(8'hFF, 8'hFF, 100);
        chk("pre_reset_hex", bus.hex_word, 32'h7654_3310);
        hold(8'hFD, 8'hA4, 10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_hex", bus.hex_word, 32'd0);
        chk("async_rst_digit", 32'(bus.digit), 32'd0);
        chk("async_rst_idx", 32'(bus.digit_idx), 32'd0);
        exp_hex = 32'd0;
        exp_mask = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_valid(1, 4'h2, 1'b0);
        hold(8'hFD, 8'hA4, 20);
        hold(8'hFF, 8'hFF, 20);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_rx_decoder.md
# seg7_rx_decoder

Receive-side decoder for the team's multiplexed 7-segment bus (active-low segments, active-low digit enables). It samples the segment/enable lines driven by the display-driver blocks, waits for each pattern to settle, decodes it back to a 4-bit hex value plus decimal point, and assembles an 8-digit word. It sits in self-checking benches and loopback designs as the reader for the display writer, flagging illegal patterns and illegal enable combinations.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical samples required before a pattern is accepted; legal range 2..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `c`  in  8  segment bus, active-low; bit7 = dp, bits6..0 = g..a.
- `en`  in  8  digit enables, active-low; bit i low selects digit i.
- `digit`  out  4  last decoded hex value.
- `digit_idx`  out  3  position of the last decoded digit.
- `dp`  out  1  decimal point of the last decoded digit, 1 = lit.
- `valid`  out  1  one-cycle pulse: `digit`/`digit_idx`/`dp` updated.
- `err`  out  1  one-cycle pulse: settled sample was illegal.
- `hex_word`  out  32  assembled display; nibble i = last digit decoded at position i.
- `frame_done`  out  1  one-cycle pulse: all 8 positions decoded since the previous pulse.

## Operation
- Decode table on `c[6:0]` (dp masked), with dp off shown as the full byte: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E. Any other 7-bit pattern is illegal.
- Sample register `s_q = {en,c}` loads every edge.
- Run counter: when the incoming `{en,c}` differs from `s_q`, the counter loads 1; otherwise it increments, saturating at STABLE_CYCLES.
- FSM states:
  - WAIT: when run == STABLE_CYCLES, evaluate the sample and go to HELD.
  - HELD: no evaluation. Any input change returns the FSM to WAIT with run = 1.
- Evaluation of `s_q`:
  - `en` all ones (blank): no pulse, no update.
  - `en` with more than one zero bit: `err`.
  - `en` with exactly one zero bit and an illegal pattern: `err`, no output update.
  - `en` with exactly one zero bit and a legal pattern: `valid`. Update `digit`, `dp = ~c[7]`, `digit_idx`, and nibble `digit_idx` of `hex_word`. Set the seen-mask bit for that position.
- When the seen mask becomes all ones, `frame_done` pulses in the same cycle as that `valid`, and the mask clears.
- Re-decoding a position already in the mask overwrites its nibble and leaves the mask unchanged.
- A pattern that holds for fewer than STABLE_CYCLES samples (a glitch) produces nothing.
- The same pattern reappearing after any other pattern (including blank) is reported again.

## Timing
- All outputs are registered. Reset values: `digit` 0, `digit_idx` 0, `dp` 0, `valid` 0, `err` 0, `hex_word` 0, `frame_done` 0. Internal reset values: mask 0, `s_q` = 16'hFFFF, run 0, FSM in WAIT.
- Latency: if edge 0 first captures pattern X, run reaches STABLE_CYCLES at edge STABLE_CYCLES-1. Outputs update at edge STABLE_CYCLES, and `valid`/`err` are high for exactly one cycle after that edge.
- Each settled pattern produces at most one pulse. `valid` and `err` are never high together.
- Asserting `rst_n` low at any time clears everything immediately, including a pattern that is mid-count. After release, counting restarts from the `s_q` reset value.
- A change on the very edge where run would reach STABLE_CYCLES reloads run to 1, and no event occurs.

## Test plan
- Hold `en`=FE, `c`=C0 for 20 cycles with STABLE_CYCLES=16 -> exactly one `valid` at edge 16 with `digit`=0, `digit_idx`=0, `dp`=0, and `hex_word`=0000_0000.
- Cycle digits 0..7 on positions 0..7 (`en`=FE, FD, …, 7F; codes C0..F8), 20 cycles each -> 8 `valid` pulses, `hex_word`=7654_3210, and `frame_done` coincident with the 8th `valid` only.
- Hold `c`=C0 on `en`=FE, then insert a 5-cycle glitch `c`=F9, then return to C0 -> first `valid` (digit 0), no event for the glitch, second `valid` (digit 0) 16 cycles after the return.
- Hold `c`=FF on `en`=FE, then `c`=40 on `en`=FC, 20 cycles each -> two `err` pulses with no `valid`, and `hex_word` unchanged. `c`=40 decodes as digit 0 with `dp`=1 only when `en` is one-hot.
- Hold `en`=FF for 100 cycles -> no `valid`, `err`, or `frame_done`.
- Pulse `rst_n` low at count 10 of a settling pattern, then keep the pattern held -> outputs 0 immediately, and `valid` arrives 16 edges after reset release.
